// File: rtl/toggle_event_rx_if.sv
// Signal bundle for toggle_event_rx: toggle input, event status and the timestamp stream.
// The slave modport is the receiver side; master is the side that drives stimulus.
interface toggle_event_rx_if #(
  parameter int unsigned TS_W = 8
);
  logic            tog_in;
  logic            out_ready;
  logic            clr_ovf;
  logic            q;
  logic            qbar;
  logic            evt_pulse;
  logic            out_valid;
  logic [TS_W-1:0] out_data;
  logic            ovf;
  logic [7:0]      drop_cnt;

  modport master (
    output tog_in, out_ready, clr_ovf,
    input  q, qbar, evt_pulse, out_valid, out_data, ovf, drop_cnt
  );

  modport slave (
    input  tog_in, out_ready, clr_ovf,
    output q, qbar, evt_pulse, out_valid, out_data, ovf, drop_cnt
  );
endinterface

// File: rtl/toggle_event_rx.sv
// Receives a remote T-flop toggle line, turns every level change into an event pulse and
// queues the free-running timestamp of each event in a first-word-fall-through FIFO.
module toggle_event_rx #(
  parameter int unsigned TS_W  = 8,
  parameter int unsigned DEPTH = 4
) (
  input logic              clk,
  input logic              reset_n,
  toggle_event_rx_if.slave bus
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic            s1_q, s2_q, q_q, evt_q;
  logic [TS_W-1:0] ts_q;
  logic [TS_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      drop_q, drop_d;
  logic            empty, full, push, pop, drop, wr_en;

  // Synchroniser, edge history and timestamp counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      q_q   <= 1'b0;
      evt_q <= 1'b0;
      ts_q  <= '0;
    end else begin
      s1_q  <= bus.tog_in;
      s2_q  <= s1_q;
      q_q   <= s2_q;
      evt_q <= s2_q ^ q_q;
      ts_q  <= ts_q + 1'b1;
    end
  end

  always_comb begin
    empty = (cnt_q == '0);
    full  = (cnt_q == FullCnt);
    push  = evt_q;
    pop   = !empty && bus.out_ready;
    // A pop on the same edge frees the slot, so only a push into a full, non-popping FIFO drops.
    drop  = push && full && !pop;
    wr_en = push && !drop;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (wr_en && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !wr_en) begin
      cnt_d = cnt_q - 1'b1;
    end

    // A drop outranks a coincident clear: the new loss is still reported.
    if (drop) begin
      ovf_d = 1'b1;
      if (bus.clr_ovf) begin
        drop_d = 8'd1;
      end else if (drop_q != 8'hff) begin
        drop_d = drop_q + 1'b1;
      end
    end else if (bus.clr_ovf) begin
      ovf_d  = 1'b0;
      drop_d = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= 8'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  // Storage needs no reset: out_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= ts_q;
    end
  end

  assign bus.q         = q_q;
  assign bus.qbar      = ~q_q;
  assign bus.evt_pulse = evt_q;
  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.ovf       = ovf_q;
  assign bus.drop_cnt  = drop_q;

endmodule

// File: doc/toggle_event_rx.md
TOGGLE_EVENT_RX -- requirements
Module: toggle_event_rx

Interface
- REQ-001: Parameter TS_W, default 8, timestamp and free-running counter width in bits.
- REQ-002: Parameter DEPTH, default 4, event FIFO depth in entries; power of two, minimum 2.
- REQ-003: clk  input  1  single clock; all state SHALL update on its rising edge.
- REQ-004: reset_n  input  1  reset, asynchronous and active-low.
- REQ-005: tog_in  input  1  toggle line from a remote T flip-flop; asynchronous to clk; every level change is one event.
- REQ-006: out_ready  input  1  consumer accepts the head entry when high.
- REQ-007: clr_ovf  input  1  synchronous clear of ovf and drop_cnt.
- REQ-008: q  output  1  reconstructed toggle level (synchronised tog_in).
- REQ-009: qbar  output  1  always the inverse of q.
- REQ-010: evt_pulse  output  1  one-cycle pulse per detected toggle.
- REQ-011: out_valid  output  1  FIFO non-empty.
- REQ-012: out_data  output  TS_W  timestamp of the head entry; drives 0 when out_valid is 0.
- REQ-013: ovf  output  1  sticky flag set by a lost event.
- REQ-014: drop_cnt  output  8  count of lost events, saturating.

Function
- REQ-015: tog_in SHALL pass through a two-flop synchroniser (s1, s2) and then a history register q; the block SHALL have no other path from tog_in.
- REQ-016: evt_pulse SHALL be registered and high for exactly one cycle, beginning on the edge after s2 differs from q; q takes s2 on that same edge.
- REQ-017: Latency: a tog_in change sampled at edge k SHALL raise evt_pulse and update q at edge k+2.
- REQ-018: Both rising and falling toggles SHALL each produce exactly one evt_pulse.
- REQ-019: Toggles spaced at least 2 cycles apart SHALL each be detected.
- REQ-020: ts_cnt (TS_W bits, internal) SHALL increment every cycle from 0 after reset and wrap from 2^TS_W-1 to 0.
- REQ-021: FIFO write SHALL occur at the edge that ends an evt_pulse cycle, storing the ts_cnt value present during that cycle.
- REQ-022: The FIFO SHALL be first-word-fall-through: out_valid rises on the write edge into an empty FIFO.
- REQ-023: Pop SHALL occur on an edge where out_valid and out_ready are both 1; out_ready while empty has no effect.
- REQ-024: On a write into a full FIFO with no pop on the same edge, the entry SHALL be discarded, ovf set, and drop_cnt incremented, saturating at 255.
- REQ-025: On a write into a full FIFO with a pop on the same edge, both operations SHALL occur and no drop is recorded.
- REQ-026: Simultaneous write and pop on a single-entry FIFO SHALL leave exactly the new entry with out_valid=1.
- REQ-027: Pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked so that full and empty are unambiguous.
- REQ-028: clr_ovf SHALL zero ovf and drop_cnt on the next edge; a drop on that same edge SHALL take priority (ovf=1, drop_cnt=1).

Reset
- REQ-029: While reset_n=0: s1=s2=q=0, qbar=1, evt_pulse=0, ts_cnt=0, FIFO empty (out_valid=0, out_data=0), ovf=0, drop_cnt=0.
- REQ-030: Asserting reset_n mid-operation SHALL discard FIFO contents and any in-flight toggle immediately.
- REQ-031: If tog_in=1 at reset release, the block SHALL report exactly one event, 2 edges after the first edge that samples it.

Verification
- REQ-032: Reset release, tog_in 0->1 sampled at edge 5 -> evt_pulse high after edge 7, q=1/qbar=0, out_data=7 with out_valid=1 after edge 8.
- REQ-033: 4 toggles 3 cycles apart, out_ready=0 -> 4 entries, increasing timestamps 3 apart, ovf=0; a 5th toggle -> ovf=1, drop_cnt=1, FIFO unchanged.
- REQ-034: FIFO full, out_ready=1 on the write edge of a 5th toggle -> no drop, oldest entry popped, newest entry appended.
- REQ-035: Toggle timed so that ts_cnt=255 during the pulse cycle, next toggle 2 cycles later -> entries 255 then 1 (wrap).
- REQ-036: 300 drops -> drop_cnt=255; clr_ovf -> 0/0; clr_ovf coincident with a drop -> ovf=1, drop_cnt=1.
- REQ-037: reset_n pulsed low with 3 entries queued -> out_valid=0, q=0, qbar=1 asynchronously; no evt_pulse from the discarded toggle.
